// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low patterns (bit 6 = g, bit 0 = a),
// readback FSM states and the decoded value width.
package seg7_pkg;

  localparam int VALUE_W = 20;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Forward encoding used by the display driver; digits above 9 show blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational reverse lookup from an active-low segment pattern to a decimal digit.
// Blank decodes as 0 and is valid; anything unrecognised yields 0 with valid low.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: digit = 4'd0;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_readback.sv
// Snapshots the HEX segment bus on start and decodes one digit per cycle,
// most significant first, into a decimal value with an invalid-digit flag.
module seg7_readback
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7*NUM_DIGITS-1:0] seg_bus,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [VALUE_W-1:0]      value,
  output logic                    err,
  output logic [2:0]              err_digit
);

  state_t                  state_p0;
  logic [7*NUM_DIGITS-1:0] shadow_p0;
  logic [2:0]              idx_p0;
  logic [VALUE_W-1:0]      acc_p0;
  logic                    scan_err_p0;
  logic [2:0]              scan_err_idx_p0;

  logic [6:0]              cur_seg;
  logic [3:0]              cur_digit;
  logic                    cur_valid;
  logic [VALUE_W-1:0]      acc_next;
  logic                    load;
  logic                    last;

  // acc*10 + d built from shifts so no multiplier is inferred.
  function automatic logic [VALUE_W-1:0] mac10(input logic [VALUE_W-1:0] a,
                                               input logic [3:0]         d);
    return (a << 3) + (a << 1) + VALUE_W'(d);
  endfunction

  assign load = (state_p0 == IDLE) && start;
  assign last = (state_p0 == SCAN) && (idx_p0 == 3'd0);

  always_comb begin
    cur_seg = SEG_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_p0 == 3'(i)) cur_seg = shadow_p0[7*i +: 7];
    end
  end

  seg7_to_bcd u_dec (
    .seg   (cur_seg),
    .digit (cur_digit),
    .valid (cur_valid)
  );

  assign acc_next = mac10(acc_p0, cur_digit);

  // Stage p0: shadow capture and per-digit accumulation (datapath, not reset).
  always_ff @(posedge clk) begin
    if (load) begin
      shadow_p0       <= seg_bus;
      idx_p0          <= 3'(NUM_DIGITS - 1);
      acc_p0          <= '0;
      scan_err_p0     <= 1'b0;
      scan_err_idx_p0 <= 3'd0;
    end else if (state_p0 == SCAN) begin
      acc_p0 <= acc_next;
      idx_p0 <= idx_p0 - 3'd1;
      if (!cur_valid && !scan_err_p0) begin
        scan_err_p0     <= 1'b1;
        scan_err_idx_p0 <= idx_p0;
      end
    end
  end

  // Stage p1: control FSM and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0  <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      value     <= '0;
      err       <= 1'b0;
      err_digit <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state_p0)
        IDLE: begin
          if (start) begin
            state_p0 <= SCAN;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          if (last) begin
            state_p0  <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            value     <= acc_next;
            err       <= scan_err_p0 | ~cur_valid;
            err_digit <= scan_err_p0 ? scan_err_idx_p0 : 3'd0;
          end
        end
        default: begin
          state_p0 <= IDLE;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_readback.sv
// Directed bench for seg7_readback: six-digit instance plus a one-digit instance.
module tb_seg7_readback;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] PA = 7'b0001000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [41:0] seg_bus = '1;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [19:0] value;
  logic [2:0]  err_digit;

  logic [6:0]  seg_bus1 = '1;
  logic        start1 = 1'b0;
  logic        busy1, done1, err1;
  logic [19:0] value1;
  logic [2:0]  err_digit1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg7_readback #(.NUM_DIGITS(6)) dut (
    .clk(clk), .reset(reset), .seg_bus(seg_bus), .start(start),
    .busy(busy), .done(done), .value(value), .err(err), .err_digit(err_digit)
  );

  seg7_readback #(.NUM_DIGITS(1)) dut1 (
    .clk(clk), .reset(reset), .seg_bus(seg_bus1), .start(start1),
    .busy(busy1), .done(done1), .value(value1), .err(err1), .err_digit(err_digit1)
  );

  // Drives one start and waits (bounded) for done; returns observations only.
  task automatic run_scan(input logic [41:0] bus, output int lat, output int busy_cnt,
                          output logic [19:0] v, output logic e, output logic [2:0] ed);
    seg_bus = bus;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    v = value; e = err; ed = err_digit;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; start1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (value !== 20'd0) begin n_bad++; $display("FAIL reset_value got %0d want 0", value); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_vec++; if (err_digit !== 3'd0) begin n_bad++; $display("FAIL reset_err_digit got %0d want 0", err_digit); end
    n_vec++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin n_bad++; $display("FAIL reset_dut1 got busy=%b done=%b want 0 0", busy1, done1); end
    reset = 1'b0; start = 1'b0; start1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_quiet cycle %0d got done=%b busy=%b want 0 0", c, done, busy); end
    end
  endtask

  task automatic test_decimal;
    int lat, bc; logic [19:0] v; logic e; logic [2:0] ed;
    run_scan({P1, P2, P3, P4, P5, P6}, lat, bc, v, e, ed);
    n_vec++; if (lat !== 6) begin n_bad++; $display("FAIL dec_latency got %0d want 6", lat); end
    n_vec++; if (bc !== 6) begin n_bad++; $display("FAIL dec_busy_cycles got %0d want 6", bc); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dec_busy_at_done got %b want 0", busy); end
    n_vec++; if (v !== 20'd123456) begin n_bad++; $display("FAIL dec_value got %0d want 123456", v); end
    n_vec++; if (e !== 1'b0 || ed !== 3'd0) begin n_bad++; $display("FAIL dec_err got %b/%0d want 0/0", e, ed); end
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b0 || value !== 20'd123456) begin n_bad++; $display("FAIL dec_hold got done=%b value=%0d want 0 123456", done, value); end
    run_scan({P9, P8, P7, P6, P5, P0}, lat, bc, v, e, ed);
    n_vec++; if (v !== 20'd987650 || e !== 1'b0) begin n_bad++; $display("FAIL dec_987650 got %0d/%b want 987650/0", v, e); end
  endtask

  task automatic test_blank;
    int lat, bc; logic [19:0] v; logic e; logic [2:0] ed;
    run_scan({BL, BL, P0, P0, P4, P2}, lat, bc, v, e, ed);
    n_vec++; if (v !== 20'd42) begin n_bad++; $display("FAIL blank_value got %0d want 42", v); end
    n_vec++; if (e !== 1'b0 || ed !== 3'd0) begin n_bad++; $display("FAIL blank_err got %b/%0d want 0/0", e, ed); end
    n_vec++; if (lat !== 6) begin n_bad++; $display("FAIL blank_latency got %0d want 6", lat); end
  endtask

  task automatic test_one_digit;
    seg_bus1 = P9;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n_vec++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin n_bad++; $display("FAIL one_busy got busy=%b done=%b want 1 0", busy1, done1); end
    @(posedge clk); #1;
    n_vec++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin n_bad++; $display("FAIL one_done got done=%b busy=%b want 1 0", done1, busy1); end
    n_vec++; if (value1 !== 20'd9 || err1 !== 1'b0) begin n_bad++; $display("FAIL one_value got %0d/%b want 9/0", value1, err1); end
    seg_bus1 = PA;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (done1 !== 1'b1 || value1 !== 20'd0 || err1 !== 1'b1 || err_digit1 !== 3'd0) begin
      n_bad++; $display("FAIL one_invalid got done=%b value=%0d err=%b ed=%0d want 1 0 1 0", done1, value1, err1, err_digit1);
    end
  endtask

  task automatic test_invalid;
    int lat, bc; logic [19:0] v; logic e; logic [2:0] ed;
    run_scan({P1, P1, PA, P1, PA, P1}, lat, bc, v, e, ed);
    n_vec++; if (v !== 20'd110101) begin n_bad++; $display("FAIL inv_value got %0d want 110101", v); end
    n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL inv_err got %b want 1", e); end
    n_vec++; if (ed !== 3'd3) begin n_bad++; $display("FAIL inv_err_digit got %0d want 3", ed); end
    run_scan({P2, P2, P2, P2, P2, PA}, lat, bc, v, e, ed);
    n_vec++; if (v !== 20'd222220 || e !== 1'b1 || ed !== 3'd0) begin
      n_bad++; $display("FAIL inv_lsd got %0d/%b/%0d want 222220/1/0", v, e, ed);
    end
    run_scan({P3, P3, P3, P3, P3, P3}, lat, bc, v, e, ed);
    n_vec++; if (v !== 20'd333333 || e !== 1'b0 || ed !== 3'd0) begin
      n_bad++; $display("FAIL inv_clear got %0d/%b/%0d want 333333/0/0", v, e, ed);
    end
  endtask

  task automatic test_back_to_back;
    int dones;
    seg_bus = {P9, P8, P7, P6, P5, P4};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (c == 1) start = 1'b1;
      if (c == 2) begin start = 1'b0; seg_bus = {P0, P0, P0, P0, P0, P0}; end
      if (c == 3) start = 1'b1;
      if (c == 4) start = 1'b0;
    end
    n_vec++; if (dones !== 1 || done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done got count=%0d done=%b want 1 1", dones, done); end
    n_vec++; if (value !== 20'd987654) begin n_bad++; $display("FAIL b2b_captured got %0d want 987654", value); end
    seg_bus = {P1, P3, P5, P7, P9, P0};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL b2b_restart got busy=%b done=%b want 1 0", busy, done); end
    dones = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c < 6 && done) dones++;
    end
    n_vec++; if (dones !== 0 || done !== 1'b1) begin n_bad++; $display("FAIL b2b_second_done got early=%0d done=%b want 0 1", dones, done); end
    n_vec++; if (value !== 20'd135790) begin n_bad++; $display("FAIL b2b_second_value got %0d want 135790", value); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    int dones, lat, bc; logic [19:0] v; logic e; logic [2:0] ed;
    run_scan({PA, P1, P1, P1, P1, P1}, lat, bc, v, e, ed);
    seg_bus = {P5, P5, P5, P5, P5, P5};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_ctrl got busy=%b done=%b want 0 0", busy, done); end
    n_vec++; if (value !== 20'd0 || err !== 1'b0 || err_digit !== 3'd0) begin
      n_bad++; $display("FAIL abort_outputs got %0d/%b/%0d want 0/0/0", value, err, err_digit);
    end
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    n_vec++; if (dones !== 0) begin n_bad++; $display("FAIL abort_quiet got %0d active cycles want 0", dones); end
    run_scan({P0, P0, P0, P1, P2, P3}, lat, bc, v, e, ed);
    n_vec++; if (lat !== 6 || v !== 20'd123 || e !== 1'b0) begin
      n_bad++; $display("FAIL abort_recover got lat=%0d value=%0d err=%b want 6 123 0", lat, v, e);
    end
  endtask

  initial begin
    test_reset;
    test_decimal;
    test_blank;
    test_one_digit;
    test_invalid;
    test_back_to_back;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
